// File: rtl/evt_fifo_p_pkg.sv
// Shared definitions for the event FIFO: capacity and entry-width derivations
// plus the per-cycle operation encoding used by the occupancy logic.
package evt_fifo_p_pkg;

  // One slot is sacrificed so a full FIFO never aliases read and write addresses.
  function automatic int unsigned fifo_cap(input int unsigned aw);
    return (32'd1 << aw) - 32'd1;
  endfunction

  // Entry layout is {PHASE, FLAG[NCH-1:0], DIN[NCH*DW-1:0]}.
  function automatic int unsigned entry_width(input int unsigned nch, input int unsigned dw);
    return nch * (dw + 32'd1) + 32'd1;
  endfunction

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/evt_fifo_ram.sv
// Simple dual-port RAM: synchronous write, registered synchronous read, no reset.
module evt_fifo_ram #(
  parameter int AW = 8,
  parameter int EW = 16
) (
  input  logic          CLK,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [EW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [EW-1:0] rd_data
);

  logic [EW-1:0] mem [2**AW];

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/evt_fifo_p.sv
// Multi-lane event FIFO: NCH data lanes plus per-lane flags and a phase tag
// share one pointer/occupancy set; sticky overflow/underflow error reporting.
module evt_fifo_p
  import evt_fifo_p_pkg::*;
#(
  parameter int DW       = 4,
  parameter int NCH      = 3,
  parameter int AW       = 8,
  parameter int AFULL_TH = 240
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR,
  input  logic              PUSH,
  input  logic              POP,
  input  logic [NCH*DW-1:0] DIN,
  input  logic [NCH-1:0]    FLAG,
  input  logic              PHASE,
  output logic [NCH*DW-1:0] DOUT,
  output logic [NCH-1:0]    DFLAG,
  output logic              DPHASE,
  output logic              DVALID,
  output logic [AW-1:0]     COUNT,
  output logic              EMPTY,
  output logic              FULL,
  output logic              AFULL,
  output logic              FULL_NXT,
  output logic              OVF,
  output logic              UDF
);

  localparam int            CAP    = int'(fifo_cap(AW));
  localparam int            EW     = int'(entry_width(NCH, DW));
  localparam logic [AW-1:0] CAP_V  = AW'(CAP);
  localparam logic [AW-1:0] CAP_M1 = AW'(CAP - 1);
  localparam logic [AW-1:0] TH_V   = AW'(AFULL_TH);

  logic [AW-1:0] wr_ptr, rd_ptr, count, count_nxt;
  logic          empty, full, afull, ovf, udf, dvalid;
  logic          has_data;
  logic          ce_wr, ce_rd;
  fifo_op_e      op;
  logic [EW-1:0] wr_entry, rd_entry;

  assign ce_wr = PUSH & ~full  & ~CLR;
  assign ce_rd = POP  & ~empty & ~CLR;

  always_comb begin
    op        = fifo_op_e'({ce_wr, ce_rd});
    count_nxt = count;
    case (op)
      OP_WR:   count_nxt = count + AW'(1);
      OP_RD:   count_nxt = count - AW'(1);
      default: count_nxt = count;
    endcase
  end

  assign FULL_NXT = ~ce_rd & (full | (ce_wr & (count == CAP_M1)));

  // Control state: pointers, occupancy, flags and sticky errors.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      afull    <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
      dvalid   <= 1'b0;
      has_data <= 1'b0;
    end else if (CLR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      afull  <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
      dvalid <= 1'b0;
    end else begin
      if (ce_wr) wr_ptr <= wr_ptr + AW'(1);
      if (ce_rd) rd_ptr <= rd_ptr + AW'(1);
      count  <= count_nxt;
      empty  <= (count_nxt == '0);
      full   <= (count_nxt == CAP_V);
      afull  <= (count_nxt >= TH_V);
      ovf    <= ovf | (PUSH & full);
      udf    <= udf | (POP & empty);
      dvalid <= ce_rd;
      if (ce_rd) has_data <= 1'b1;
    end
  end

  assign wr_entry = {PHASE, FLAG, DIN};

  evt_fifo_ram #(
    .AW (AW),
    .EW (EW)
  ) u_ram (
    .CLK     (CLK),
    .wr_en   (ce_wr),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .rd_en   (ce_rd),
    .rd_addr (rd_ptr),
    .rd_data (rd_entry)
  );

  // The RAM read register has no reset; mask it until the first real pop so
  // outputs read zero out of reset. CLR leaves the last popped entry visible.
  assign {DPHASE, DFLAG, DOUT} = has_data ? rd_entry : '0;

  assign DVALID = dvalid;
  assign COUNT  = count;
  assign EMPTY  = empty;
  assign FULL   = full;
  assign AFULL  = afull;
  assign OVF    = ovf;
  assign UDF    = udf;

endmodule

// File: tb/tb_evt_fifo_p.sv
// Directed self-checking bench for evt_fifo_p with default parameters.
module tb_evt_fifo_p;

  logic        CLK = 1'b0;
  logic        RST, CLR, PUSH, POP, PHASE;
  logic [11:0] DIN;
  logic [2:0]  FLAG;
  logic [11:0] DOUT;
  logic [2:0]  DFLAG;
  logic        DPHASE, DVALID, EMPTY, FULL, AFULL, FULL_NXT, OVF, UDF;
  logic [7:0]  COUNT;

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  evt_fifo_p dut (
    .CLK      (CLK),
    .RST      (RST),
    .CLR      (CLR),
    .PUSH     (PUSH),
    .POP      (POP),
    .DIN      (DIN),
    .FLAG     (FLAG),
    .PHASE    (PHASE),
    .DOUT     (DOUT),
    .DFLAG    (DFLAG),
    .DPHASE   (DPHASE),
    .DVALID   (DVALID),
    .COUNT    (COUNT),
    .EMPTY    (EMPTY),
    .FULL     (FULL),
    .AFULL    (AFULL),
    .FULL_NXT (FULL_NXT),
    .OVF      (OVF),
    .UDF      (UDF)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] wrap_entry(input int i);
    logic [31:0] v;
    v = i;
    return {v[1], v[2:0], 12'(i * 7 + 3)};
  endfunction

  logic [11:0] d3 [3] = '{12'h123, 12'h456, 12'h789};
  logic [2:0]  f3 [3] = '{3'b101, 3'b010, 3'b111};

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b1; CLR = 1'b0; PUSH = 1'b0; POP = 1'b0;
    DIN = '0; FLAG = '0; PHASE = 1'b0;
    repeat (3) tick();
    chk("rst_count", COUNT, 0);
    chk("rst_empty", EMPTY, 1);
    chk("rst_full", FULL, 0);
    chk("rst_afull", AFULL, 0);
    chk("rst_ovf", OVF, 0);
    chk("rst_udf", UDF, 0);
    chk("rst_dvalid", DVALID, 0);
    chk("rst_dout", {DPHASE, DFLAG, DOUT}, 0);
    RST = 1'b0;
    tick();

    // Basic push 3 / pop 3
    for (int i = 0; i < 3; i++) begin
      PUSH = 1'b1; DIN = d3[i]; FLAG = f3[i]; PHASE = (i == 1);
      tick();
    end
    PUSH = 1'b0;
    chk("b3_count", COUNT, 3);
    chk("b3_empty", EMPTY, 0);
    for (int i = 0; i < 3; i++) begin
      POP = 1'b1;
      tick();
      chk("b3_dout", DOUT, d3[i]);
      chk("b3_dflag", DFLAG, f3[i]);
      chk("b3_dphase", DPHASE, (i == 1));
      chk("b3_dvalid", DVALID, 1);
    end
    POP = 1'b0;
    tick();
    chk("b3_dvalid_off", DVALID, 0);
    chk("b3_dout_hold", DOUT, 12'h789);
    chk("b3_empty_end", EMPTY, 1);
    chk("b3_count_end", COUNT, 0);

    // Almost-full threshold
    for (int i = 0; i < 240; i++) begin
      PUSH = 1'b1; DIN = 12'(i);
      tick();
      if (i == 238) chk("af_239", AFULL, 0);
    end
    PUSH = 1'b0;
    chk("af_240", AFULL, 1);
    chk("af_count", COUNT, 240);
    POP = 1'b1;
    tick();
    POP = 1'b0;
    chk("af_pop", AFULL, 0);
    chk("af_pop_count", COUNT, 239);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    chk("clr_count", COUNT, 0);
    chk("clr_empty", EMPTY, 1);
    chk("clr_afull", AFULL, 0);
    chk("clr_dvalid", DVALID, 0);

    // Fill to capacity, then overflow
    for (int i = 0; i < 255; i++) begin
      PUSH = 1'b1; DIN = 12'(i + 1);
      #1;
      if (i == 253) chk("fn_253", FULL_NXT, 0);
      if (i == 254) chk("fn_255th", FULL_NXT, 1);
      tick();
    end
    chk("full_flag", FULL, 1);
    chk("full_count", COUNT, 255);
    chk("full_ovf0", OVF, 0);
    chk("full_fn_hold", FULL_NXT, 1);
    tick();
    chk("ovf_set", OVF, 1);
    chk("ovf_count", COUNT, 255);
    POP = 1'b1;
    tick();
    PUSH = 1'b0; POP = 1'b0;
    chk("pp_full_count", COUNT, 254);
    chk("pp_full_full", FULL, 0);
    chk("pp_full_ovf", OVF, 1);
    chk("pp_full_dvalid", DVALID, 1);
    chk("pp_full_dout", DOUT, 12'h001);

    // Push+pop from empty
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    chk("clr_ovf", OVF, 0);
    chk("clr_udf", UDF, 0);
    PUSH = 1'b1; POP = 1'b1; DIN = 12'hABC; FLAG = 3'b011; PHASE = 1'b1;
    tick();
    PUSH = 1'b0; POP = 1'b0;
    chk("pp_emp_count", COUNT, 1);
    chk("pp_emp_udf", UDF, 1);
    chk("pp_emp_dvalid", DVALID, 0);
    chk("pp_emp_empty", EMPTY, 0);
    POP = 1'b1;
    tick();
    POP = 1'b0;
    chk("pp_emp_dout", {DPHASE, DFLAG, DOUT}, 16'hBABC);
    chk("pp_emp_udf_hold", UDF, 1);

    // Wrap-around streaming
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    for (int i = 0; i < 600; i++) begin
      logic [15:0] e;
      e = wrap_entry(i);
      PUSH = 1'b1; POP = (i > 0);
      {PHASE, FLAG, DIN} = e;
      tick();
      if (i > 0) begin
        chk("wrap_data", {DPHASE, DFLAG, DOUT}, wrap_entry(i - 1));
        chk("wrap_dvalid", DVALID, 1);
      end
    end
    POP = 1'b0;
    PUSH = 1'b1; {PHASE, FLAG, DIN} = 16'h0111;
    tick();
    DIN = 12'h222;
    tick();
    PUSH = 1'b0;
    chk("wrap_count", COUNT, 3);

    // Asynchronous reset mid-stream
    #2;
    RST = 1'b1;
    #1;
    chk("arst_count", COUNT, 0);
    chk("arst_empty", EMPTY, 1);
    chk("arst_dvalid", DVALID, 0);
    chk("arst_dout", {DPHASE, DFLAG, DOUT}, 0);
    tick();
    RST = 1'b0;
    tick();
    PUSH = 1'b1; {PHASE, FLAG, DIN} = 16'h45A5;
    tick();
    PUSH = 1'b0; POP = 1'b1;
    tick();
    POP = 1'b0;
    chk("post_rst_dout", {DPHASE, DFLAG, DOUT}, 16'h45A5);
    chk("post_rst_dvalid", DVALID, 1);
    chk("post_rst_count", COUNT, 0);
    chk("post_rst_empty", EMPTY, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/evt_fifo_p.md
EVT_FIFO_P -- requirements
Module: evt_fifo_p

Interface
REQ-001 Parameter DW, default 4: data bits per channel lane.
REQ-002 Parameter NCH, default 3: number of independent channel lanes sharing one pointer/flag set.
REQ-003 Parameter AW, default 8: address width; physical depth 2^AW, usable capacity CAP = 2^AW-1.
REQ-004 Parameter AFULL_TH, default 240: almost-full threshold, range 1..CAP.
REQ-005 CLK  input  1  system clock; all state on rising edge.
REQ-006 RST  input  1  reset, asynchronous, active-high.
REQ-007 CLR  input  1  synchronous flush; empties FIFO and clears sticky errors.
REQ-008 PUSH  input  1  write request.
REQ-009 POP  input  1  read request.
REQ-010 DIN  input  NCH*DW  write data; lane k = DIN[k*DW +: DW].
REQ-011 FLAG  input  NCH  per-lane status bit stored with each lane word.
REQ-012 PHASE  input  1  shared phase tag stored with every entry.
REQ-013 DOUT  output  NCH*DW  read data, lane order as DIN.
REQ-014 DFLAG  output  NCH  stored FLAG of the read entry.
REQ-015 DPHASE  output  1  stored PHASE of the read entry.
REQ-016 DVALID  output  1  one-cycle strobe: DOUT/DFLAG/DPHASE hold a newly popped entry.
REQ-017 COUNT  output  AW  current occupancy, 0..CAP.
REQ-018 EMPTY, FULL, AFULL  output  1 each  registered occupancy flags.
REQ-019 FULL_NXT  output  1  combinational: FULL value for next cycle.
REQ-020 OVF, UDF  output  1 each  sticky overflow / underflow errors.

Function
REQ-021 Accepted write ce_wr = PUSH & !FULL & !CLR; accepted read ce_rd = POP & !EMPTY & !CLR.
REQ-022 PUSH while FULL is dropped, even with simultaneous POP; it sets OVF on the next edge.
REQ-023 POP while EMPTY is dropped, even with simultaneous PUSH; it sets UDF on the next edge.
REQ-024 Write and read pointers are AW-bit binary counters, incremented on ce_wr / ce_rd, wrapping 2^AW-1 -> 0.
REQ-025 COUNT increments on ce_wr only, decrements on ce_rd only, unchanged on both or neither.
REQ-026 EMPTY registers (COUNT_next == 0); FULL registers (COUNT_next == CAP); AFULL registers (COUNT_next >= AFULL_TH).
REQ-027 FULL_NXT = !ce_rd & (FULL | (ce_wr & COUNT == CAP-1)).
REQ-028 Each entry stores {PHASE, FLAG, DIN} as captured in the ce_wr cycle.
REQ-029 Read latency 1: data of an accepted POP appears on outputs at the next edge with DVALID=1; outputs hold until the next accepted POP.
REQ-030 Write and read of the same address in one cycle cannot occur (capacity CAP guarantees it); no bypass path.
REQ-031 CLR: pointers, COUNT, OVF, UDF -> 0; EMPTY=1; FULL=AFULL=0; DVALID=0; RAM contents and DOUT untouched.

Reset
REQ-032 RST asserted: pointers=0, COUNT=0, EMPTY=1, FULL=0, AFULL=0, OVF=0, UDF=0, DVALID=0, DOUT/DFLAG/DPHASE=0.
REQ-033 RST mid-operation discards all stored entries; first PUSH after release writes address 0.
REQ-034 RAM array has no reset; contents after reset are don't-care and unobservable.

Structure
REQ-035 Shared include holds CAP derivation and the entry width expression NCH*(DW+1)+1.
REQ-036 One sub-module, evt_fifo_ram: simple dual-port RAM, 2^AW x entry width, sync write, registered sync read, no reset.
REQ-037 Pointer, count and flag logic lives in evt_fifo_p; no vendor primitives instantiated directly.

Verification
REQ-038 Defaults; PUSH 3 entries DIN=0x123,0x456,0x789, then POP 3 -> DOUT 0x123,0x456,0x789 one cycle after each POP, DVALID pulses x3, EMPTY=1, COUNT=0.
REQ-039 PUSH 255 times -> FULL=1 after 255th, COUNT=255, FULL_NXT=1 during 255th push; 256th PUSH -> OVF=1, COUNT stays 255.
REQ-040 At COUNT=255 assert PUSH+POP together -> pop accepted, push dropped, COUNT=254, FULL=0, OVF=1.
REQ-041 From empty assert PUSH+POP together -> push accepted, COUNT=1, UDF=1, DVALID=0.
REQ-042 AFULL: fill to 239 -> AFULL=0; 240th push -> AFULL=1; one pop -> AFULL=0.
REQ-043 Wrap: 600 interleaved push/pop with incrementing data -> in-order output; then RST mid-stream -> COUNT=0, EMPTY=1, next push/pop returns new data.
